// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Fully synchronous oversampling UART receiver. A baud tick
//               enable derived from clk drives a mid-bit sampler; each word
//               carries parity, framing and overrun flags and leaves through
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int DATA_W = 8,
    parameter int OS     = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        data_len,
    input  logic              parity_en,
    input  logic [1:0]        parity_mode,
    input  logic              stop_bit_size,
    input  logic              rx,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int               OS_W      = $clog2(OS);
    localparam logic [OS_W-1:0]  C_OS_LAST = OS_W'(OS - 1);
    localparam logic [OS_W-1:0]  C_OS_MID  = OS_W'(OS / 2 - 1);
    localparam logic [3:0]       C_DATA_W  = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // line synchroniser and edge history
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q,    rx_s_d;
    logic rx_prev_q, rx_prev_d;

    // timing counters
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [OS_W-1:0]  os_cnt_q,   os_cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;

    // per-frame configuration snapshot
    logic [3:0]       len_q,   len_d;
    logic             pen_q,   pen_d;
    logic [1:0]       pmode_q, pmode_d;
    logic             stop2_q, stop2_d;

    // frame accumulation
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              par_acc_q, par_acc_d;
    logic              perr_q,    perr_d;
    logic              ferr_q,    ferr_d;

    // output holding register
    logic [DATA_W-1:0] data_q,     data_d;
    logic              valid_q,    valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_out_q, ferr_out_d;
    logic              ovr_q,      ovr_d;

    logic              w_tick;
    logic              w_fall;
    logic              w_bit_end;
    logic              w_done;
    logic [DATA_W-1:0] w_in_msb;
    logic [3:0]        w_len_eff;

    // synchroniser chain, edge detect and baud tick generator
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        w_fall    = rx_prev_q & ~rx_s_q;
        w_tick    = (state_q != S_IDLE) && (baud_cnt_q == baud_div);
        w_bit_end = w_tick && (os_cnt_q == C_OS_LAST);
        if (state_q == S_IDLE || w_tick) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    // frame length of 0 or beyond DATA_W falls back to the full width
    always_comb begin
        if (data_len == 4'd0 || data_len > C_DATA_W) begin
            w_len_eff = C_DATA_W;
        end else begin
            w_len_eff = data_len;
        end
        w_in_msb = DATA_W'(rx_s_q) << (DATA_W - 1);
    end

    // receive FSM: next state, bit counting and frame accumulation
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        len_d      = len_q;
        pen_d      = pen_q;
        pmode_d    = pmode_q;
        stop2_d    = stop2_q;
        shreg_d    = shreg_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        w_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                os_cnt_d = '0;
                if (w_fall) begin
                    len_d      = w_len_eff;
                    pen_d      = parity_en;
                    pmode_d    = parity_mode;
                    stop2_d    = stop_bit_size;
                    shreg_d    = '0;
                    par_acc_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (os_cnt_q == C_OS_MID) begin
                        // still low at mid-bit: genuine start; else a glitch
                        os_cnt_d = '0;
                        state_d  = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    os_cnt_d  = '0;
                    shreg_d   = (shreg_q >> 1) | w_in_msb;
                    par_acc_d = par_acc_q ^ rx_s_q;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if ((bit_cnt_q + 4'd1) == len_q) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end
                end else if (w_tick) begin
                    os_cnt_d = os_cnt_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    os_cnt_d = '0;
                    perr_d   = rx_s_q ^ (pmode_q[0] ^ (pmode_q[1] & par_acc_q));
                    state_d  = S_STOP;
                end else if (w_tick) begin
                    os_cnt_d = os_cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    os_cnt_d = '0;
                    ferr_d   = ferr_q | ~rx_s_q;
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (w_tick) begin
                    os_cnt_d = os_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                os_cnt_d = '0;
            end
        endcase
    end

    // output register: load on completion unless a word is held and not taken
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = ovr_q;
        if (w_done) begin
            if (!valid_q || ready_i) begin
                data_d     = shreg_q >> (C_DATA_W - len_q);
                perr_out_d = perr_q;
                ferr_out_d = ferr_d;
                valid_d    = 1'b1;
                ovr_d      = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // datapath, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            len_q      <= '0;
            pen_q      <= 1'b0;
            pmode_q    <= '0;
            stop2_q    <= 1'b0;
            shreg_q    <= '0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_prev_q  <= rx_prev_d;
            baud_cnt_q <= baud_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            len_q      <= len_d;
            pen_q      <= pen_d;
            pmode_q    <= pmode_d;
            stop2_q    <= stop2_d;
            shreg_q    <= shreg_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Self-checking bench for uart_rx_os: directed vector table,
//               multi-cycle corner sequences and a randomized scoreboard run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int DATA_W = 8;
    localparam int OS     = 16;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIV_W-1:0]  baud_div;
    logic [3:0]        data_len;
    logic              parity_en;
    logic [1:0]        parity_mode;
    logic              stop_bit_size;
    logic              rx;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    uart_rx_os #(.DATA_W(DATA_W), .OS(OS), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .data_len(data_len),
        .parity_en(parity_en), .parity_mode(parity_mode),
        .stop_bit_size(stop_bit_size), .rx(rx), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one serial bit lasts (baud_div+1)*OS clocks; called on a negedge
    task automatic hold_bit(input logic v, input int ncyc);
        rx = v;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit, input int nstop, input logic [1:0] stops);
        int bc;
        bc = (int'(baud_div) + 1) * OS;
        hold_bit(1'b0, bc);
        for (int i = 0; i < nbits; i++) hold_bit(d[i], bc);
        if (pen) hold_bit(pbit, bc);
        for (int i = 0; i < nstop; i++) hold_bit(stops[i], bc);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        int n;
        n = 0;
        while (!valid_o && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, valid_o, 1);
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("consume_valid", valid_o, 0);
        chk("consume_ovr", overrun, 0);
    endtask

    // ticks from start edge to final stop mid-sample, per spec framing
    function automatic int frame_ticks(input int nbits, input int par, input int nstop);
        return OS / 2 + OS * (nbits + par + nstop);
    endfunction

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         txb;
        logic       pen;
        logic [1:0] mode;
        logic       stop2;
        logic       pbit;
        logic [1:0] stops;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vt[12];

    // scoreboard for the randomized phase
    logic [9:0] sbq[$];
    logic [9:0] sb_e;
    logic       sb_on = 1'b0;
    int         n_got = 0;
    int         t_rise = 0;
    logic       v_prev = 1'b0;

    // valid rise timestamp and scoreboard comparison on each handshake
    always @(negedge clk) begin
        if (valid_o && !v_prev) t_rise = cyc;
        v_prev = valid_o;
        if (sb_on && valid_o && ready_i) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", valid_o, 0);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_word", {22'd0, data_o, parity_err, frame_err}, {22'd0, sb_e});
                chk("sb_ovr", overrun, 0);
            end
            n_got++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, t0, tc, bd, len, eff, pen, stop2;
        logic [7:0] d, ed;
        logic [1:0] mode, stops;
        logic pbit, ep, pe, fe, seen;

        rst = 1'b1; rx = 1'b1; ready_i = 1'b0;
        baud_div = 16'd3; data_len = 4'd8; parity_en = 1'b0;
        parity_mode = 2'b00; stop_bit_size = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_flags", {parity_err, frame_err, overrun}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        //                data   len   txb pen  mode   st2  pbit  stops  exp_d  pe    fe
        vt[0]  = '{8'hA5, 4'd8,  8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vt[1]  = '{8'h55, 4'd7,  7, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11, 8'h55, 1'b0, 1'b0};
        vt[2]  = '{8'h55, 4'd7,  7, 1'b1, 2'b10, 1'b0, 1'b1, 2'b11, 8'h55, 1'b1, 1'b0};
        vt[3]  = '{8'h55, 4'd7,  7, 1'b1, 2'b11, 1'b0, 1'b1, 2'b11, 8'h55, 1'b0, 1'b0};
        vt[4]  = '{8'h0F, 4'd4,  4, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 8'h0F, 1'b1, 1'b0};
        vt[5]  = '{8'h0F, 4'd4,  4, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 8'h0F, 1'b0, 1'b0};
        vt[6]  = '{8'hC3, 4'd0,  8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 8'hC3, 1'b0, 1'b0};
        vt[7]  = '{8'hFF, 4'd5,  5, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 8'h1F, 1'b0, 1'b0};
        vt[8]  = '{8'h96, 4'd12, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 8'h96, 1'b0, 1'b0};
        vt[9]  = '{8'h5A, 4'd8,  8, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
        vt[10] = '{8'h6B, 4'd8,  8, 1'b1, 2'b10, 1'b1, 1'b1, 2'b11, 8'h6B, 1'b0, 1'b0};
        vt[11] = '{8'h6B, 4'd8,  8, 1'b1, 2'b11, 1'b0, 1'b1, 2'b11, 8'h6B, 1'b1, 1'b0};

        bc = 4 * OS;
        for (int i = 0; i < 12; i++) begin
            data_len = vt[i].len; parity_en = vt[i].pen; parity_mode = vt[i].mode;
            stop_bit_size = vt[i].stop2;
            t0 = cyc;
            send_frame(vt[i].data, vt[i].txb, vt[i].pen, vt[i].pbit,
                       vt[i].stop2 ? 2 : 1, vt[i].stops);
            wait_valid($sformatf("vec%0d_valid", i), 4 * bc);
            chk($sformatf("vec%0d_data", i), data_o, vt[i].exp_d);
            chk($sformatf("vec%0d_pe", i), parity_err, vt[i].exp_pe);
            chk($sformatf("vec%0d_fe", i), frame_err, vt[i].exp_fe);
            chk($sformatf("vec%0d_ovr", i), overrun, 0);
            if (i == 0) begin
                chk("vec0_latency", t_rise - t0, 3 + 4 * frame_ticks(8, 0, 1));
                repeat (2 * bc) @(negedge clk);
                chk("vec0_hold_valid", valid_o, 1);
                chk("vec0_hold_data", data_o, 8'hA5);
            end
            consume();
            repeat (5) @(negedge clk);
        end

        // short low glitch: false start, no word
        data_len = 4'd8; parity_en = 1'b0; stop_bit_size = 1'b0;
        hold_bit(1'b0, 3 * 4);
        rx = 1'b1;
        chk("glitch_busy_hi", busy, 1);
        repeat (40) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_valid", valid_o, 0);

        // framing error followed by a held-low break
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 2'b00);
        rx = 1'b0;
        wait_valid("brk_valid", 4 * bc);
        chk("brk_data", data_o, 8'h3C);
        chk("brk_fe", frame_err, 1);
        consume();
        seen = 1'b0;
        for (int n = 0; n < 20 * bc; n++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        chk("brk_no_retrigger", seen, 0);
        chk("brk_busy", busy, 0);
        rx = 1'b1;
        repeat (2 * bc) @(negedge clk);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_valid("brk2_valid", 4 * bc);
        chk("brk2_data", data_o, 8'h81);
        chk("brk2_fe", frame_err, 0);
        consume();
        repeat (5) @(negedge clk);

        // overrun: two frames while consumer stalls
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 2'b11);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 2'b11);
        repeat (4) @(negedge clk);
        chk("ovr_valid", valid_o, 1);
        chk("ovr_data", data_o, 8'h11);
        chk("ovr_flag", overrun, 1);
        consume();
        repeat (5) @(negedge clk);

        // completion coinciding with handshake of the held word
        send_frame(8'h44, 8, 1'b0, 1'b0, 1, 2'b11);
        repeat (4) @(negedge clk);
        chk("sim_held", data_o, 8'h44);
        t0 = cyc;
        tc = t0 + 2 + 4 * frame_ticks(8, 0, 1);
        fork
            send_frame(8'h55, 8, 1'b0, 1'b0, 1, 2'b11);
            begin
                while (cyc < tc) @(negedge clk);
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
            end
        join
        chk("sim_valid", valid_o, 1);
        chk("sim_data", data_o, 8'h55);
        chk("sim_ovr", overrun, 0);
        consume();
        repeat (5) @(negedge clk);

        // consumer ready throughout: one-cycle valid pulse
        ready_i = 1'b1;
        seen = 1'b0;
        fork
            send_frame(8'h33, 8, 1'b0, 1'b0, 1, 2'b11);
            begin
                for (int n = 0; n < 20 * bc && !seen; n++) begin
                    @(negedge clk);
                    if (valid_o) begin
                        seen = 1'b1;
                        chk("r33_data", data_o, 8'h33);
                        chk("r33_ovr", overrun, 0);
                    end
                end
            end
        join
        chk("r33_seen", seen, 1);
        ready_i = 1'b0;
        repeat (5) @(negedge clk);

        // reset in the middle of DATA with a word held
        send_frame(8'h77, 8, 1'b0, 1'b0, 1, 2'b11);
        repeat (4) @(negedge clk);
        chk("rstm_held", data_o, 8'h77);
        hold_bit(1'b0, bc);
        hold_bit(1'b1, bc);
        hold_bit(1'b1, bc / 2);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_busy", busy, 0);
        chk("rstm_valid", valid_o, 0);
        chk("rstm_data", data_o, 0);
        chk("rstm_flags", {parity_err, frame_err, overrun}, 0);
        repeat (2 * bc) @(negedge clk);
        stop_bit_size = 1'b1;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 2, 2'b11);
        wait_valid("rstm2_valid", 4 * bc);
        chk("rstm2_data", data_o, 8'h5A);
        chk("rstm2_fe", frame_err, 0);
        consume();
        repeat (5) @(negedge clk);

        // randomized frames against the reference model
        sb_on = 1'b1;
        ready_i = 1'b1;
        n_got = 0;
        for (int f = 0; f < 30; f++) begin
            bd    = $urandom_range(0, 2);
            len   = $urandom_range(0, 10);
            d     = 8'($urandom);
            pen   = $urandom_range(0, 1);
            mode  = 2'($urandom);
            stop2 = $urandom_range(0, 1);
            pbit  = 1'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            eff   = (len == 0 || len > DATA_W) ? DATA_W : len;
            ed    = d & 8'((1 << eff) - 1);
            ep    = mode[0] ^ (mode[1] & ($countones(ed) % 2 == 1));
            pe    = (pen != 0) && (pbit != ep);
            fe    = (stops[0] == 1'b0) || ((stop2 != 0) && (stops[1] == 1'b0));
            sbq.push_back({ed, pe, fe});
            baud_div = 16'(bd); data_len = 4'(len); parity_en = 1'(pen);
            parity_mode = mode; stop_bit_size = 1'(stop2);
            send_frame(d, eff, 1'(pen), pbit, (stop2 != 0) ? 2 : 1, stops);
            repeat ($urandom_range(2, 20)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        chk("sb_left", sbq.size(), 0);
        chk("sb_count", n_got, 30);
        sb_on = 1'b0;
        ready_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Fully synchronous, parametrised UART receiver. It supersedes the derived-clock receiver: the clk domain drives all logic, and an internal baud tick enable feeds an oversampling sampler.
Data width, oversampling factor and divisor width are parameters. Each word carries parity-error, framing-error and overrun flags and leaves through a valid/ready output handshake.
The block sits between the rx pin and the transceiver's data-path logic.

Parameters:
DATA_W, 8, maximum data bits per frame (1..9)
OS, 16, oversample ticks per bit (even, >=4)
DIV_W, 16, width of baud_div

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
baud_div  in  DIV_W  oversample tick period minus one, in clk cycles
data_len  in  4  data bits per frame; 0 or >DATA_W is treated as DATA_W
parity_en  in  1  parity bit present
parity_mode  in  2  11 odd, 10 even, 01 mark(1), 00 space(0)
stop_bit_size  in  1  0: 1 stop bit; 1: 2 stop bits
rx  in  1  serial line, asynchronous, idle high
data_o  out  DATA_W  received word, right-justified, unused MSBs 0
valid_o  out  1  data_o and flags valid
ready_i  in  1  consumer accepts the word
parity_err  out  1  parity mismatch for the held word
frame_err  out  1  a stop-bit sample of the held word was 0
overrun  out  1  at least one frame was lost while this word was held
busy  out  1  state != IDLE

Behaviour:
- Synchroniser: rx passes through 2 FFs (rx_s); both reset to 1. Falling-edge detect is rx_s(prev)=1 and rx_s=0.
- Tick generator: counter 0..baud_div; tick is asserted when counter==baud_div, then the counter wraps to 0. It is held at 0 in IDLE, which realigns the phase on each start edge. baud_div=0 gives a tick every cycle.
- os_cnt counts ticks within a bit and clears on every state transition.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge, latch data_len, parity_en, parity_mode and stop_bit_size, then go to START. Config changes mid-frame have no effect on the current frame.
- START: on the tick where os_cnt==OS/2-1 (mid-bit), go to DATA if rx_s==0. Otherwise treat it as a false start: return to IDLE with no output and no flags.
- DATA: sample rx_s every OS ticks (mid-bit). Bits are LSB first, shifted into a buffer from the MSB end. After the latched data_len bits, go to PARITY if parity_en, else STOP.
- PARITY: sample one bit. Expected value = mode[0] ^ (mode[1] & XOR of data bits). parity_err = sample != expected. Without parity_en, parity_err=0.
- STOP: sample 1 or 2 stop bits; frame_err = any stop sample == 0. Go to IDLE on the tick of the last stop sample.
- A low line after a framing error (break) does not retrigger; the line must return high and fall again.
- Output register: the cycle after the final stop-sample tick, data_o is loaded with buffer >> (DATA_W - len), plus parity_err and frame_err; valid_o = 1.
- Handshake: the word is consumed when valid_o && ready_i. valid_o drops the next cycle unless a new word loads in the same cycle.
- Simultaneous completion and handshake: the new word loads, valid_o stays 1, overrun=0.
- Completion with valid_o=1 and no handshake: the new word is discarded, data_o and its flags are kept, and overrun is set. overrun stays set until the held word is consumed.
- Reset: aborts any frame. Outputs go to data_o=0, valid_o=0, parity_err=0, frame_err=0, overrun=0, busy=0; state IDLE; all counters 0.

Test Plan:
1. baud_div=3, OS=16, data_len=8, no parity, 1 stop; send 0xA5 -> data_o=0xA5, valid_o=1, all flags 0. valid_o rises 1 cycle after the stop mid-sample tick and stays until ready_i=1.
2. data_len=7, even parity; send 0x55 with parity bit 0 -> data_o=0x55, parity_err=0. Repeat with parity bit 1 -> parity_err=1. With odd parity, bit 1 -> parity_err=0.
3. Low glitch on rx of 3 ticks (below OS/2) -> no valid_o; busy returns to 0 by the mid-start tick.
4. Send 0x3C with stop bit 0 and hold the line low for 20 bit times -> data_o=0x3C, frame_err=1, no further frames. Release high then send 0x81 -> data_o=0x81, frame_err=0.
5. ready_i=0; send 0x11 then 0x22 back to back -> data_o=0x11, overrun=1. Pulse ready_i -> valid_o=0, overrun=0. Then 0x33 with ready_i=1 during its completion cycle -> data_o=0x33, overrun=0.
6. Assert rst for 1 cycle mid-DATA -> next cycle busy=0, valid_o=0, all outputs 0. A subsequent frame 0x5A with 2 stop bits is received correctly.
